// File: rtl/sort4_seq_ctrl.sv
// Four-operand ascending sorter built around one shared compare-exchange unit (5 steps per sort).
// Optional SORT4_SWAPCNT_EN adds a swap_cnt output reporting the swaps of the last finished sort.
module sort4_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ra,
    output logic [WIDTH-1:0] rb,
    output logic [WIDTH-1:0] rc,
    output logic [WIDTH-1:0] rd
`ifdef SORT4_SWAPCNT_EN
    ,
    output logic [2:0]       swap_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q;
    logic [2:0]             step_q;
    logic [3:0][WIDTH-1:0]  w_q;
    logic [3:0][WIDTH-1:0]  w_d;
    logic [3:0][WIDTH-1:0]  r_q;
    logic                   busy_q;
    logic                   done_q;
    logic [1:0]             i_sel;
    logic [1:0]             j_sel;
    logic [WIDTH-1:0]       x;
    logic [WIDTH-1:0]       y;
    logic                   swap;
`ifdef SORT4_SWAPCNT_EN
    logic [2:0]             cnt_q;
    logic [2:0]             swap_cnt_q;
`endif

    // Network order: (0,1) (2,3) (0,2) (1,3) (1,2)
    always_comb begin
        i_sel = 2'd1;
        j_sel = 2'd2;
        case (step_q)
            3'd0:    begin i_sel = 2'd0; j_sel = 2'd1; end
            3'd1:    begin i_sel = 2'd2; j_sel = 2'd3; end
            3'd2:    begin i_sel = 2'd0; j_sel = 2'd2; end
            3'd3:    begin i_sel = 2'd1; j_sel = 2'd3; end
            default: begin i_sel = 2'd1; j_sel = 2'd2; end
        endcase
        x    = w_q[i_sel];
        y    = w_q[j_sel];
        swap = (x > y);
        w_d  = w_q;
        if (swap) begin
            w_d[i_sel] = y;
            w_d[j_sel] = x;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            step_q     <= 3'd0;
            w_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SORT4_SWAPCNT_EN
            cnt_q      <= 3'd0;
            swap_cnt_q <= 3'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        w_q     <= {d, c, b, a};
                        step_q  <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
`ifdef SORT4_SWAPCNT_EN
                        cnt_q   <= 3'd0;
`endif
                    end
                end
                S_RUN: begin
                    w_q <= w_d;
`ifdef SORT4_SWAPCNT_EN
                    cnt_q <= cnt_q + {2'b00, swap};
`endif
                    if (step_q == 3'd4) begin
                        r_q     <= w_d;
                        done_q  <= 1'b1;
                        step_q  <= 3'd0;
                        state_q <= S_DONE;
`ifdef SORT4_SWAPCNT_EN
                        swap_cnt_q <= cnt_q + {2'b00, swap};
`endif
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    // A start seen during DONE chains straight into the next sort.
                    if (start) begin
                        w_q     <= {d, c, b, a};
                        step_q  <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
`ifdef SORT4_SWAPCNT_EN
                        cnt_q   <= 3'd0;
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ra   = r_q[0];
    assign rb   = r_q[1];
    assign rc   = r_q[2];
    assign rd   = r_q[3];
`ifdef SORT4_SWAPCNT_EN
    assign swap_cnt = swap_cnt_q;
`endif

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Scoreboard bench for sort4_seq_ctrl: driver pushes expected sorted results, monitor pops on done.
module tb_sort4_seq_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b, c, d;
    logic         busy, done;
    logic [W-1:0] ra, rb, rc, rd;
`ifdef SORT4_SWAPCNT_EN
    logic [2:0]   swap_cnt;
`endif

    sort4_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .done(done),
        .ra(ra), .rb(rb), .rc(rc), .rd(rd)
`ifdef SORT4_SWAPCNT_EN
        , .swap_cnt(swap_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][W-1:0] r;
        int                swaps;
        int                due;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0][W-1:0] ref_sort(input logic [W-1:0] p0, p1, p2, p3);
        logic [W-1:0] v[4];
        logic [W-1:0] t;
        logic [3:0][W-1:0] o;
        v[0] = p0; v[1] = p1; v[2] = p2; v[3] = p3;
        for (int i = 1; i < 4; i++)
            for (int j = i; j > 0; j--)
                if (v[j-1] > v[j]) begin t = v[j]; v[j] = v[j-1]; v[j-1] = t; end
        for (int i = 0; i < 4; i++) o[i] = v[i];
        return o;
    endfunction

    // Swaps performed by the fixed exchange sequence (0,1)(2,3)(0,2)(1,3)(1,2).
    function automatic int ref_swaps(input logic [W-1:0] p0, p1, p2, p3);
        int v[4];
        int pi[5];
        int pj[5];
        int n, t;
        v[0] = p0; v[1] = p1; v[2] = p2; v[3] = p3;
        pi[0] = 0; pj[0] = 1; pi[1] = 2; pj[1] = 3; pi[2] = 0; pj[2] = 2;
        pi[3] = 1; pj[3] = 3; pi[4] = 1; pj[4] = 2;
        n = 0;
        for (int s = 0; s < 5; s++)
            if (v[pi[s]] > v[pj[s]]) begin
                t = v[pi[s]]; v[pi[s]] = v[pj[s]]; v[pj[s]] = t; n++;
            end
        return n;
    endfunction

    task automatic push_exp(input logic [W-1:0] p0, p1, p2, p3);
        exp_t e;
        e.r     = ref_sort(p0, p1, p2, p3);
        e.swaps = ref_swaps(p0, p1, p2, p3);
        e.due   = cyc + 5;
        sbq.push_back(e);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 40; k++) begin
            if (!busy || done) return;
            @(negedge clk);
        end
        n_cmp++; n_bad++;
        $display("FAIL ready_timeout: busy=%0b done=%0b, required ready within 40 cycles", busy, done);
    endtask

    // Start is raised only when the DUT can accept it, so every issue maps to one expected done.
    task automatic issue(input logic [W-1:0] p0, p1, p2, p3, input bit keep);
        wait_ready();
        a = p0; b = p1; c = p2; d = p3;
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(p0, p1, p2, p3);
        if (!keep) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_done: done at cycle %0d with no sort outstanding, result %0h", cyc, {rd, rc, rb, ra});
            end else begin
                exp_t e;
                e = sbq.pop_front();
                n_cmp++;
                if ({rd, rc, rb, ra} !== e.r) begin
                    n_bad++;
                    $display("FAIL result: got %0h, required %0h", {rd, rc, rb, ra}, e.r);
                end
                n_cmp++;
                if (cyc != e.due) begin
                    n_bad++;
                    $display("FAIL latency: done at cycle %0d, required cycle %0d", cyc, e.due);
                end
`ifdef SORT4_SWAPCNT_EN
                n_cmp++;
                if (int'(swap_cnt) != e.swaps) begin
                    n_bad++;
                    $display("FAIL swap_cnt: got %0d, required %0d", swap_cnt, e.swaps);
                end
`endif
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        #100;
        reset = 1'b0;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'({rd, rc, rb, ra}), 64'd0);
        repeat (10) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_result", 64'({rd, rc, rb, ra}), 64'd0);

        issue(8'd9, 8'd3, 8'd200, 8'd3, 1'b0);
        issue(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        issue(8'd255, 8'd128, 8'd7, 8'd0, 1'b0);
        chk("busy_in_run", 64'(busy), 64'd1);

        // Start pulsed in RUN step2 must be ignored.
        issue(8'd50, 8'd40, 8'd30, 8'd20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 8'd1; b = 8'd1; c = 8'd1; d = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Start held through RUN: operands changed mid-run, second sort taken at DONE.
        issue(8'd77, 8'd66, 8'd88, 8'd55, 1'b1);
        @(negedge clk);
        a = 8'd5; b = 8'd250; c = 8'd100; d = 8'd6;
        issue(8'd5, 8'd250, 8'd100, 8'd6, 1'b0);

        // Reset in RUN step3 aborts the sort and clears outputs asynchronously.
        issue(8'd12, 8'd34, 8'd56, 8'd78, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_result_held", 64'({rd, rc, rb, ra}), 64'({8'd250, 8'd100, 8'd6, 8'd5}));
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", 64'({rd, rc, rb, ra}), 64'd0);
        void'(sbq.pop_back());
        @(negedge clk);
        reset = 1'b0;

        issue(8'd200, 8'd100, 8'd150, 8'd50, 1'b0);
        for (int n = 0; n < 50; n++)
            issue(W'($urandom % 256), W'($urandom % 256), W'($urandom % 256), W'($urandom % 256), 1'b0);

        wait_ready();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        chk("final_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
